// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants and request enums for the instruction encoder
// and the decode controller.
package instr_encoder_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALU funct3 / funct7 field values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [6:0] F7_ZERO    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_LI     = 4'd9
    } req_class_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LI2  = 1'b1
    } enc_state_e;

    // Map an ALU code onto its funct3 field
    function automatic logic [2:0] alu_funct3(input logic [3:0] op);
        logic [2:0] f3;
        case (op)
            ALU_ADD, ALU_SUB: f3 = F3_ADD_SUB;
            ALU_SLL:          f3 = F3_SLL;
            ALU_SLT:          f3 = F3_SLT;
            ALU_SLTU:         f3 = F3_SLTU;
            ALU_XOR:          f3 = F3_XOR;
            ALU_SRL, ALU_SRA: f3 = F3_SRL_SRA;
            ALU_OR:           f3 = F3_OR;
            ALU_AND:          f3 = F3_AND;
            default:          f3 = F3_ADD_SUB;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/instr_encoder_format_pack.sv
// Combinational field packing for all instruction formats, LI expansion and
// request legality check.
module instr_format_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  req_class,
    input  logic [3:0]  req_alu_op,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic [31:0] word_first,
    output logic [31:0] word_second,
    output logic        split,
    output logic        legal
);

    logic [2:0]  f3_alu;
    logic [6:0]  f7_alu;
    logic        alu_in_range;
    logic        alu_is_shift;
    logic        li_small;
    logic [19:0] li_hi;
    logic [11:0] li_lo;

    assign f3_alu       = alu_funct3(req_alu_op);
    assign f7_alu       = (req_alu_op == ALU_SUB || req_alu_op == ALU_SRA) ? F7_ALT : F7_ZERO;
    assign alu_in_range = (req_alu_op <= 4'd9);
    assign alu_is_shift = (req_alu_op == ALU_SLL) || (req_alu_op == ALU_SRL) || (req_alu_op == ALU_SRA);
    // imm fits a 12-bit signed field when bits 31:11 are all equal
    assign li_small     = (&req_imm[31:11]) || (~|req_imm[31:11]);
    // (imm + 0x800) >> 12: adding 0x800 carries into bit 12 exactly when imm[11] is set
    assign li_hi        = req_imm[31:12] + {19'd0, req_imm[11]};
    assign li_lo        = req_imm[11:0];

    // Pack the instruction word(s) for the requested class and judge legality
    always_comb begin
        word_first  = '0;
        word_second = '0;
        split       = 1'b0;
        legal       = 1'b1;
        case (req_class)
            CLS_R: begin
                legal      = alu_in_range;
                word_first = {f7_alu, req_rs2, req_rs1, f3_alu, req_rd, OP_R};
            end
            CLS_I: begin
                legal = alu_in_range && (req_alu_op != ALU_SUB);
                if (alu_is_shift)
                    word_first = {f7_alu, req_imm[4:0], req_rs1, f3_alu, req_rd, OP_IMM};
                else
                    word_first = {req_imm[11:0], req_rs1, f3_alu, req_rd, OP_IMM};
            end
            CLS_LOAD: begin
                legal      = (req_funct3 != 3'd3) && (req_funct3 != 3'd6) && (req_funct3 != 3'd7);
                word_first = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
            end
            CLS_STORE: begin
                legal      = (req_funct3 <= 3'd2);
                word_first = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
            end
            CLS_BRANCH: begin
                legal      = (req_funct3 != 3'd2) && (req_funct3 != 3'd3) && !req_imm[0];
                word_first = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                              req_imm[4:1], req_imm[11], OP_BRANCH};
            end
            CLS_LUI: begin
                word_first = {req_imm[31:12], req_rd, OP_LUI};
            end
            CLS_AUIPC: begin
                word_first = {req_imm[31:12], req_rd, OP_AUIPC};
            end
            CLS_JAL: begin
                legal      = !req_imm[0];
                word_first = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            end
            CLS_JALR: begin
                word_first = {req_imm[11:0], req_rs1, F3_JALR, req_rd, OP_JALR};
            end
            CLS_LI: begin
                if (li_small) begin
                    word_first = {req_imm[11:0], 5'd0, F3_ADD_SUB, req_rd, OP_IMM};
                end else begin
                    word_first = {li_hi, req_rd, OP_LUI};
                    if (li_lo != 12'd0) begin
                        split       = 1'b1;
                        word_second = {li_lo, req_rd, F3_ADD_SUB, req_rd, OP_IMM};
                    end
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts compact requests, emits RV32I words with a
// sequential byte address through a single-entry output register.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_class,
    input  logic [3:0]        req_alu_op,
    input  logic [2:0]        req_funct3,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_word,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    enc_state_e        state_reg, state_next;
    logic              valid_reg, valid_next;
    logic [31:0]       word_reg, word_next;
    logic [31:0]       second_reg, second_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              err_pulse_reg, err_pulse_next;
    logic [7:0]        err_count_reg, err_count_next;
    logic              live_reg;

    logic [31:0]       pack_first;
    logic [31:0]       pack_second;
    logic              pack_split;
    logic              pack_legal;
    logic              slot_free;
    logic              accept;

    instr_format_pack u_pack (
        .req_class   (req_class),
        .req_alu_op  (req_alu_op),
        .req_funct3  (req_funct3),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .word_first  (pack_first),
        .word_second (pack_second),
        .split       (pack_split),
        .legal       (pack_legal)
    );

    assign slot_free   = !valid_reg || instr_ready;
    // live_reg keeps ready low while reset is held and for the first edge after
    assign req_ready   = live_reg && (state_reg == ST_IDLE) && slot_free && !clr;
    assign accept      = req_valid && req_ready;

    assign instr_valid = valid_reg;
    assign instr_word  = word_reg;
    assign instr_addr  = addr_reg;
    assign err_pulse   = err_pulse_reg;
    assign err_count   = err_count_reg;

    // Next-state: output slot, LI second-word sequencing, address and error tracking
    always_comb begin
        state_next     = state_reg;
        valid_next     = valid_reg;
        word_next      = word_reg;
        second_next    = second_reg;
        addr_next      = addr_reg;
        err_pulse_next = 1'b0;
        err_count_next = err_count_reg;

        if (valid_reg && instr_ready) begin
            valid_next = 1'b0;
            addr_next  = addr_reg + ADDR_W'(4);
        end

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (!pack_legal) begin
                        err_pulse_next = 1'b1;
                        if (err_count_reg != 8'hFF)
                            err_count_next = err_count_reg + 8'd1;
                    end else begin
                        valid_next = 1'b1;
                        word_next  = pack_first;
                        if (pack_split) begin
                            second_next = pack_second;
                            state_next  = ST_LI2;
                        end
                    end
                end
            end
            ST_LI2: begin
                if (slot_free) begin
                    valid_next = 1'b1;
                    word_next  = second_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // clr drops any pending word or LI tail and rewinds the address
        if (clr) begin
            valid_next = 1'b0;
            state_next = ST_IDLE;
            addr_next  = BASE_ADDR;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            valid_reg     <= 1'b0;
            word_reg      <= '0;
            second_reg    <= '0;
            addr_reg      <= BASE_ADDR;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
            live_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            valid_reg     <= valid_next;
            word_reg      <= word_next;
            second_reg    <= second_next;
            addr_reg      <= addr_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
            live_reg      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_class;
    logic [3:0]  req_alu_op;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [31:0] instr_addr;
    logic        err_pulse;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  cls;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_class   (req_class),
        .req_alu_op  (req_alu_op),
        .req_funct3  (req_funct3),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_word  (instr_word),
        .instr_addr  (instr_addr),
        .err_pulse   (err_pulse),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cls, input logic [3:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        req_class  = cls;
        req_alu_op = op;
        req_funct3 = f3;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        req_valid  = 1'b1;
    endtask

    logic [31:0] exp_addr;
    int          exp_errs;
    int          ghost;

    initial begin
        //             cls    op    f3    rd     rs1    rs2    imm            legal word
        vecs[0]  = '{4'd0, 4'd0, 3'd0, 5'd3,  5'd1,  5'd2,  32'h0,         1'b1, 32'h002081B3};
        vecs[1]  = '{4'd0, 4'd1, 3'd0, 5'd1,  5'd2,  5'd3,  32'h0,         1'b1, 32'h403100B3};
        vecs[2]  = '{4'd1, 4'd0, 3'd0, 5'd5,  5'd0,  5'd0,  32'hFFFFFFFF,  1'b1, 32'hFFF00293};
        vecs[3]  = '{4'd1, 4'd7, 3'd0, 5'd1,  5'd2,  5'd0,  32'h3,         1'b1, 32'h40315093};
        vecs[4]  = '{4'd2, 4'd0, 3'd2, 5'd5,  5'd1,  5'd0,  32'h4,         1'b1, 32'h0040A283};
        vecs[5]  = '{4'd3, 4'd0, 3'd2, 5'd0,  5'd1,  5'd2,  32'h8,         1'b1, 32'h0020A423};
        vecs[6]  = '{4'd4, 4'd0, 3'd0, 5'd0,  5'd1,  5'd2,  32'h8,         1'b1, 32'h00208463};
        vecs[7]  = '{4'd5, 4'd0, 3'd0, 5'd10, 5'd0,  5'd0,  32'hABCDE000,  1'b1, 32'hABCDE537};
        vecs[8]  = '{4'd6, 4'd0, 3'd0, 5'd1,  5'd0,  5'd0,  32'h1000,      1'b1, 32'h00001097};
        vecs[9]  = '{4'd7, 4'd0, 3'd0, 5'd1,  5'd0,  5'd0,  32'h8,         1'b1, 32'h008000EF};
        vecs[10] = '{4'd8, 4'd0, 3'd0, 5'd0,  5'd1,  5'd0,  32'h0,         1'b1, 32'h00008067};
        vecs[11] = '{4'd9, 4'd0, 3'd0, 5'd7,  5'd0,  5'd0,  32'd100,       1'b1, 32'h06400393};
        vecs[12] = '{4'd9, 4'd0, 3'd0, 5'd2,  5'd0,  5'd0,  32'h12345000,  1'b1, 32'h12345137};
        vecs[13] = '{4'd1, 4'd9, 3'd0, 5'd4,  5'd4,  5'd0,  32'hFF,        1'b1, 32'h0FF27213};
        vecs[14] = '{4'd1, 4'd1, 3'd0, 5'd1,  5'd1,  5'd0,  32'h1,         1'b0, 32'h0};
        vecs[15] = '{4'd10,4'd0, 3'd0, 5'd1,  5'd1,  5'd0,  32'h0,         1'b0, 32'h0};
        vecs[16] = '{4'd2, 4'd0, 3'd3, 5'd1,  5'd1,  5'd0,  32'h0,         1'b0, 32'h0};
        vecs[17] = '{4'd3, 4'd0, 3'd3, 5'd1,  5'd1,  5'd0,  32'h0,         1'b0, 32'h0};
        vecs[18] = '{4'd4, 4'd0, 3'd2, 5'd0,  5'd1,  5'd2,  32'h8,         1'b0, 32'h0};
        vecs[19] = '{4'd4, 4'd0, 3'd0, 5'd0,  5'd1,  5'd2,  32'h3,         1'b0, 32'h0};
        vecs[20] = '{4'd7, 4'd0, 3'd0, 5'd1,  5'd0,  5'd0,  32'h1,         1'b0, 32'h0};
        vecs[21] = '{4'd0, 4'd10,3'd0, 5'd1,  5'd1,  5'd1,  32'h0,         1'b0, 32'h0};
        vecs[22] = '{4'd0, 4'd0, 3'd0, 5'd3,  5'd1,  5'd2,  32'h0,         1'b1, 32'h002081B3};

        rst_n       = 1'b0;
        clr         = 1'b0;
        instr_ready = 1'b1;
        req_valid   = 1'b0;
        drive(4'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        req_valid   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_word", instr_word, 32'd0);
        check("rst_addr", instr_addr, 32'd0);
        check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Table: back-to-back requests, consumer always ready
        exp_addr = 32'h0;
        exp_errs = 0;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].cls, vecs[i].op, vecs[i].f3, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            check($sformatf("vec%0d_req_ready", i), {31'd0, req_ready}, 32'd1);
            @(posedge clk);
            #1;
            if (vecs[i].legal) begin
                check($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, 32'd1);
                check($sformatf("vec%0d_word", i), instr_word, vecs[i].word);
                check($sformatf("vec%0d_addr", i), instr_addr, exp_addr);
                check($sformatf("vec%0d_err_pulse", i), {31'd0, err_pulse}, 32'd0);
                exp_addr += 32'd4;
            end else begin
                exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
                check($sformatf("vec%0d_no_word", i), {31'd0, instr_valid}, 32'd0);
                check($sformatf("vec%0d_err_pulse", i), {31'd0, err_pulse}, 32'd1);
                check($sformatf("vec%0d_err_count", i), {24'd0, err_count}, exp_errs[31:0]);
            end
            $display("vec %0d class=%0d valid=%0b word=%08h addr=%08h err=%0d",
                     i, vecs[i].cls, instr_valid, instr_word, instr_addr, err_count);
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("err_pulse_one_cycle", {31'd0, err_pulse}, 32'd0);

        // Saturation of the error counter
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            drive(4'd15, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("err_count_sat", {24'd0, err_count}, 32'd255);
        $display("sat err_count=%0d", err_count);

        // LI split with a stalled consumer
        @(negedge clk);
        instr_ready = 1'b0;
        drive(4'd9, 4'd0, 3'd0, 5'd6, 5'd0, 5'd0, 32'h12345FFF);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("li_lui_valid", {31'd0, instr_valid}, 32'd1);
        check("li_lui_word", instr_word, 32'h12346337);
        check("li_lui_addr", instr_addr, exp_addr);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("li_hold%0d_word", c), instr_word, 32'h12346337);
            check($sformatf("li_hold%0d_ready", c), {31'd0, req_ready}, 32'd0);
        end
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        check("li_addi_word", instr_word, 32'hFFF30313);
        check("li_addi_valid", {31'd0, instr_valid}, 32'd1);
        check("li_addi_addr", instr_addr, exp_addr + 32'd4);
        check("li_ready_back", {31'd0, req_ready}, 32'd1);
        $display("li word=%08h addr=%08h", instr_word, instr_addr);
        exp_addr += 32'd8;
        @(posedge clk);
        #1;
        check("li_drained", {31'd0, instr_valid}, 32'd0);

        // clr drops a pending word and rewinds the address
        @(negedge clk);
        instr_ready = 1'b0;
        drive(4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0);
        @(posedge clk);
        #1;
        check("clr_pending", {31'd0, instr_valid}, 32'd1);
        @(negedge clk);
        clr = 1'b1;
        drive(4'd0, 4'd1, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        check("clr_blocks_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        clr       = 1'b0;
        req_valid = 1'b0;
        check("clr_dropped", {31'd0, instr_valid}, 32'd0);
        check("clr_addr", instr_addr, 32'h0);
        check("clr_keeps_errs", {24'd0, err_count}, 32'd255);
        @(negedge clk);
        instr_ready = 1'b1;
        drive(4'd0, 4'd1, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("clr_next_word", instr_word, 32'h403100B3);
        check("clr_next_addr", instr_addr, 32'h0);
        $display("clr word=%08h addr=%08h", instr_word, instr_addr);
        @(posedge clk);

        // Asynchronous reset while in LI2
        @(negedge clk);
        instr_ready = 1'b0;
        drive(4'd9, 4'd0, 3'd0, 5'd6, 5'd0, 5'd0, 32'h12345FFF);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("ar_lui_word", instr_word, 32'h12346337);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, instr_valid}, 32'd0);
        check("ar_word", instr_word, 32'd0);
        check("ar_addr", instr_addr, 32'd0);
        check("ar_err_count", {24'd0, err_count}, 32'd0);
        check("ar_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        instr_ready = 1'b1;
        rst_n       = 1'b1;
        ghost       = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (instr_valid) ghost++;
        end
        check("ar_no_addi", ghost, 32'd0);
        check("ar_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        drive(4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("ar_next_word", instr_word, 32'h002081B3);
        check("ar_next_addr", instr_addr, 32'h0);
        $display("post-reset word=%08h addr=%08h", instr_word, instr_addr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the decode/control path. Accepts compact instruction requests (class, alu_op code, funct3, register indices, immediate) over a valid/ready handshake and emits encoded RV32I instruction words with a sequential write address. The instruction-memory loader consumes the words, and the verification benches use it to build test programs. It expands the LI pseudo-instruction into LUI+ADDI through a two-word sequence, and flags illegal requests instead of emitting them.

Parameters:
ADDR_W, 32, width of the output word address
BASE_ADDR, 0, address of the first emitted word after reset or clr

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
clr  in  1  sync: drop pending word/state, reload address to BASE_ADDR
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_class  in  4  0 R,1 I,2 LOAD,3 STORE,4 BRANCH,5 LUI,6 AUIPC,7 JAL,8 JALR,9 LI
req_alu_op  in  4  ALU code: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND
req_funct3  in  3  width/condition for LOAD/STORE/BRANCH
req_rd, req_rs1, req_rs2  in  5 each  register indices
req_imm  in  32  immediate, sign-extended value
instr_valid  out  1  output word valid
instr_ready  in  1  consumer ready
instr_word  out  32  encoded instruction
instr_addr  out  ADDR_W  byte address of instr_word
err_pulse  out  1  one-cycle pulse: accepted request was illegal
err_count  out  8  saturating count of illegal requests

Behaviour:
- Reset values: req_ready 0 during reset then 1; instr_valid 0; instr_word 0; instr_addr BASE_ADDR; err_pulse 0; err_count 0; FSM in IDLE.
- Single-entry output register. A word is consumed on instr_valid&&instr_ready. instr_addr then advances by 4 and wraps modulo 2^ADDR_W.
- req_ready = (state==IDLE) && (!instr_valid || instr_ready).
- Latency: word appears registered one cycle after acceptance. Back-to-back throughput is 1 word/cycle.
- instr_word and instr_valid hold stable while instr_valid && !instr_ready.
- FSM states:
  - IDLE: on accept of a legal non-split request, load the word and stay in IDLE. On accept of a split LI, load the LUI word, latch the ADDI word, and go to LI2.
  - LI2: req_ready=0. When the slot frees, load the ADDI word and return to IDLE.
- Encoding:
  - R: funct7 = 0x20 for SUB/SRA, else 0.
  - I: alu_op 1 (SUB) is illegal. Shifts use imm[4:0] and funct7 0x20 for SRA.
  - LOAD: funct3 in {0,1,2,4,5}. STORE: funct3 in {0,1,2}. BRANCH: funct3 not in {2,3}.
  - BRANCH and JAL: imm[0]=1 is illegal.
  - LUI/AUIPC: use imm[31:12].
  - JALR: funct3 000.
  - Immediates are truncated to field width without a range check.
- LI: if imm is in [-2048,2047], emit a single ADDI rd,x0,imm. Otherwise:
  - hi = (imm+0x800)>>12 and lo = imm[11:0].
  - Emit LUI rd,hi, then ADDI rd,rd,lo.
  - If lo==0, emit LUI only.
- Illegal request:
  - Handling: accepted (ready semantics unchanged), no word emitted, err_pulse for 1 cycle, err_count increments and saturates at 255.
  - Which requests are illegal: class>9, R alu_op>9, I alu_op>9 or ==1, or any of the bad funct3 / imm[0] cases above.
- clr: same cycle as a pending word means the word is dropped, instr_valid goes to 0, FSM goes to IDLE, address goes to BASE_ADDR. A request presented together with clr is not accepted (req_ready=0 when clr=1). err_count is not cleared.
- Reset asserted mid-LI2 discards the second word.

Decomposition:
- Shared package holds:
  - opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111)
  - the req_class enum
  - the alu_op enum, shared with the decode controller
  - funct3/funct7 constants
- One sub-module, instr_format_pack: combinational R/I/S/B/U/J field packing plus the legality check. The top module holds the FSM, output register, address counter and error counter.

Test Plan:
- R ADD rd=3,rs1=1,rs2=2 with instr_ready=1 -> next cycle instr_valid=1, word 0x002081B3, addr BASE_ADDR. The following word is at BASE_ADDR+4.
- I ADDI rd=5,rs1=0,imm=-1, then I SRA rd=1,rs1=2,imm=3 back-to-back -> words 0xFFF00293, 0x40315093 on consecutive cycles.
- LI rd=6,imm=0x12345FFF with instr_ready=0 for 3 cycles -> 0x12346337 held stable with req_ready=0. After release it is followed by 0xFFF30313, then req_ready=1.
- STORE funct3=2,rs1=1,rs2=2,imm=8 -> 0x0020A423. Then I alu_op=1 -> no word, err_pulse 1 cycle, err_count=1.
- Pending word with instr_ready=0, assert clr -> instr_valid=0 next cycle. The next legal request is emitted at BASE_ADDR.
- Drive rst_n low during LI2 -> all outputs reach reset values asynchronously. No ADDI word appears after release.
